// File: rtl/harry_pkg.sv
// Shared types for the Harry animation sequencer: sprite pose codes,
// controller states, counter width and the run-cycle advance helper.
package harry_pkg;

  localparam int HARRY_CNT_W = 6;

  typedef enum logic [3:0] {
    HARRY_STAND  = 4'd0,
    HARRY_JUMP   = 4'd1,
    HARRY_RUN1   = 4'd2,
    HARRY_RUN2   = 4'd3,
    HARRY_RUN3   = 4'd4,
    HARRY_RUN4   = 4'd5,
    HARRY_RUN5   = 4'd6,
    HARRY_VINE   = 4'd7,
    HARRY_CLIMB1 = 4'd8,
    HARRY_CLIMB2 = 4'd9
  } harry_pose_t;

  typedef enum logic [2:0] {
    CTRL_STAND,
    CTRL_RUN,
    CTRL_JUMP,
    CTRL_VINE,
    CTRL_CLIMB
  } harry_ctrl_t;

  // Run cycle is run1..run5 and wraps back to run1.
  function automatic harry_pose_t run_next(input harry_pose_t p);
    logic [3:0] nxt;
    nxt = p + 4'd1;
    if (p == HARRY_RUN5 || p < HARRY_RUN1) return HARRY_RUN1;
    return harry_pose_t'(nxt);
  endfunction

endpackage

// File: rtl/harry_step_timer.sv
// Tick-qualified modulo counter: counts 0..period-1 on enabled ticks and
// pulses wrap on the tick where it rolls over. clear wins over enable.
module harry_step_timer
  import harry_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tick_i,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [HARRY_CNT_W-1:0] period_i,
  output logic                   wrap_o
);

  logic [HARRY_CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = tick_i && !clear_i && enable_i &&
                  (cnt_q == (period_i - HARRY_CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      if (clear_i)       cnt_d = '0;
      else if (enable_i) cnt_d = wrap_o ? '0 : cnt_q + HARRY_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/harry_anim_ctrl.sv
// Harry pose sequencer: picks the sprite pose each frame tick from input and
// contact flags. Define HARRY_FACING_EN to add the facing_left mirror output.
module harry_anim_ctrl
  import harry_pkg::*;
#(
  parameter int STEP_FRAMES  = 4,
  parameter int JUMP_FRAMES  = 32,
  parameter int CLIMB_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump_req,
  input  logic       climb_up,
  input  logic       climb_down,
  input  logic       on_ground,
  input  logic       on_vine,
  input  logic       on_ladder,
  output logic [3:0] harry_state,
  output logic       jumping
`ifdef HARRY_FACING_EN
  ,
  output logic       facing_left
`endif
);

  localparam int RUN_T   = 0;
  localparam int CLIMB_T = 1;

  harry_ctrl_t            state_q, state_d;
  harry_pose_t            pose_q, pose_d;
  logic [HARRY_CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic                   run_arm_q, run_arm_d;
  logic                   jumping_q, jumping_d;
  logic [1:0]             tmr_clear, tmr_enable, tmr_wrap;

  logic one_dir, one_climb, jump_done, state_change, stay_run, stay_climb;

  assign one_dir      = move_left ^ move_right;
  assign one_climb    = climb_up ^ climb_down;
  assign jump_done    = on_ground && (jump_cnt_q >= HARRY_CNT_W'(JUMP_FRAMES - 1));
  assign state_change = (state_d != state_q);
  assign stay_run     = (state_q == CTRL_RUN) && (state_d == CTRL_RUN);
  assign stay_climb   = (state_q == CTRL_CLIMB) && (state_d == CTRL_CLIMB);

  // Only vine can interrupt a jump; landing re-evaluates run vs stand.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      if (on_vine)                      state_d = CTRL_VINE;
      else if (state_q == CTRL_JUMP) begin
        if (jump_done)                  state_d = one_dir ? CTRL_RUN : CTRL_STAND;
      end
      else if (on_ladder)               state_d = CTRL_CLIMB;
      else if (on_ground && jump_req)   state_d = CTRL_JUMP;
      else if (on_ground && one_dir)    state_d = CTRL_RUN;
      else                              state_d = CTRL_STAND;
    end
  end

  // The run timer skips the first tick after entry, so the first pose
  // change lands STEP_FRAMES ticks after that tick.
  assign tmr_clear             = {2{state_change}};
  assign tmr_enable[RUN_T]     = stay_run && run_arm_q;
  assign tmr_enable[CLIMB_T]   = stay_climb && one_climb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_timer
    localparam int PERIOD = (gi == RUN_T) ? STEP_FRAMES : CLIMB_FRAMES;
    harry_step_timer u_timer (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .tick_i   (frame_tick),
      .clear_i  (tmr_clear[gi]),
      .enable_i (tmr_enable[gi]),
      .period_i (HARRY_CNT_W'(PERIOD)),
      .wrap_o   (tmr_wrap[gi])
    );
  end

  always_comb begin
    pose_d     = pose_q;
    jump_cnt_d = jump_cnt_q;
    run_arm_d  = run_arm_q;
    jumping_d  = jumping_q;
    if (frame_tick) begin
      run_arm_d = stay_run;
      jumping_d = (state_d == CTRL_JUMP);
      if (state_d != CTRL_JUMP)          jump_cnt_d = '0;
      else if (state_q != CTRL_JUMP)     jump_cnt_d = '0;
      else if (jump_cnt_q < HARRY_CNT_W'(JUMP_FRAMES))
                                         jump_cnt_d = jump_cnt_q + HARRY_CNT_W'(1);
      unique case (state_d)
        CTRL_STAND: pose_d = HARRY_STAND;
        CTRL_JUMP:  pose_d = HARRY_JUMP;
        CTRL_VINE:  pose_d = HARRY_VINE;
        CTRL_RUN: begin
          if (!stay_run)                pose_d = HARRY_RUN1;
          else if (tmr_wrap[RUN_T])     pose_d = run_next(pose_q);
        end
        CTRL_CLIMB: begin
          if (!stay_climb)              pose_d = HARRY_CLIMB1;
          else if (tmr_wrap[CLIMB_T])
            pose_d = (pose_q == HARRY_CLIMB1) ? HARRY_CLIMB2 : HARRY_CLIMB1;
        end
        default:                        pose_d = HARRY_STAND;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= CTRL_STAND;
      pose_q     <= HARRY_STAND;
      jump_cnt_q <= '0;
      run_arm_q  <= 1'b0;
      jumping_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pose_q     <= pose_d;
      jump_cnt_q <= jump_cnt_d;
      run_arm_q  <= run_arm_d;
      jumping_q  <= jumping_d;
    end
  end

  assign harry_state = pose_q;
  assign jumping     = jumping_q;

`ifdef HARRY_FACING_EN
  logic facing_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                    facing_q <= 1'b0;
    else if (frame_tick && move_left && !move_right) facing_q <= 1'b1;
    else if (frame_tick && move_right && !move_left) facing_q <= 1'b0;
  end

  assign facing_left = facing_q;
`endif

endmodule

// File: tb/tb_harry_anim_ctrl.sv
// Self-checking bench for harry_anim_ctrl: directed scenarios plus random
// stimulus against a rule-level pose model.
module tb_harry_anim_ctrl;

  localparam int STEP_FRAMES  = 4;
  localparam int JUMP_FRAMES  = 32;
  localparam int CLIMB_FRAMES = 8;

  localparam int M_STAND = 0, M_RUN = 1, M_JUMP = 2, M_VINE = 3, M_CLIMB = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, jump_req = 1'b0;
  logic       climb_up = 1'b0, climb_down = 1'b0;
  logic       on_ground = 1'b0, on_vine = 1'b0, on_ladder = 1'b0;
  logic [3:0] harry_state;
  logic       jumping;
`ifdef HARRY_FACING_EN
  logic       facing_left;
  bit         m_face;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  // Model: current state, ticks since entering it, and climb-active ticks.
  int m_st, m_k, m_n;

  harry_anim_ctrl #(
    .STEP_FRAMES (STEP_FRAMES),
    .JUMP_FRAMES (JUMP_FRAMES),
    .CLIMB_FRAMES(CLIMB_FRAMES)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .move_left  (move_left),
    .move_right (move_right),
    .jump_req   (jump_req),
    .climb_up   (climb_up),
    .climb_down (climb_down),
    .on_ground  (on_ground),
    .on_vine    (on_vine),
    .on_ladder  (on_ladder),
    .harry_state(harry_state),
    .jumping    (jumping)
`ifdef HARRY_FACING_EN
    ,
    .facing_left(facing_left)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_st = M_STAND;
    m_k  = 0;
    m_n  = 0;
`ifdef HARRY_FACING_EN
    m_face = 1'b0;
`endif
  endfunction

  function automatic void model_tick();
    int ns;
    bit one_dir;
    one_dir = (move_left != move_right);
    if (on_vine)                                            ns = M_VINE;
    else if (m_st == M_JUMP && !(m_k + 1 >= JUMP_FRAMES && on_ground == 1'b1))
                                                            ns = M_JUMP;
    else if (m_st == M_JUMP)                                ns = one_dir ? M_RUN : M_STAND;
    else if (on_ladder)                                     ns = M_CLIMB;
    else if (on_ground && jump_req)                         ns = M_JUMP;
    else if (on_ground && one_dir)                          ns = M_RUN;
    else                                                    ns = M_STAND;
    if (ns != m_st) begin
      m_k = 0;
      m_n = 0;
    end else begin
      m_k++;
      if (ns == M_CLIMB && climb_up != climb_down) m_n++;
    end
    m_st = ns;
`ifdef HARRY_FACING_EN
    if (move_left && !move_right)      m_face = 1'b1;
    else if (move_right && !move_left) m_face = 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_pose();
    case (m_st)
      M_RUN:   return (m_k == 0) ? 4'd2 : 4'(2 + ((m_k - 1) / STEP_FRAMES) % 5);
      M_CLIMB: return 4'(8 + (m_n / CLIMB_FRAMES) % 2);
      M_JUMP:  return 4'd1;
      M_VINE:  return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  task automatic tick_cycle(input bit t);
    @(negedge Clk);
    frame_tick = t;
    @(posedge Clk);
    if (t) model_tick();
    #1;
    frame_tick = 1'b0;
    n_cycle++;
    $display("cyc %0d tick=%0b L/R=%0b%0b jr=%0b gnd=%0b vine=%0b lad=%0b up/dn=%0b%0b -> pose=%0d jumping=%0b (model %0d)",
             n_cycle, t, move_left, move_right, jump_req, on_ground, on_vine, on_ladder,
             climb_up, climb_down, harry_state, jumping, model_pose());
  endtask

  task automatic clear_inputs();
    move_left = 0; move_right = 0; jump_req = 0; climb_up = 0; climb_down = 0;
    on_ground = 0; on_vine = 0; on_ladder = 0;
  endtask

  task automatic restart();
    clear_inputs();
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if (harry_state !== 4'd0 || jumping !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pose=%0d jumping=%0b, required 0/0", harry_state, jumping);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick_cycle(1'b1);
      n_checks++;
      if (harry_state !== 4'd0 || jumping !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stand: tick %0d pose=%0d jumping=%0b, required 0/0", i, harry_state, jumping);
      end
    end
  endtask

  task automatic test_run();
    logic [3:0] exp_pose;
    restart();
    on_ground = 1; move_right = 1;
    for (int i = 0; i < 26; i++) begin
      if (i == 12) begin move_right = 0; move_left = 1; end
      tick_cycle(1'b1);
      exp_pose = model_pose();
      n_checks++;
      if (harry_state !== exp_pose || jumping !== 1'b0) begin
        n_fail++;
        $display("FAIL run_seq: tick %0d pose=%0d jumping=%0b, required %0d/0", i, harry_state, jumping, exp_pose);
      end
      if (i == 4 || i == 5 || i == 21) begin
        n_checks++;
        if (harry_state !== ((i == 5) ? 4'd3 : 4'd2)) begin
          n_fail++;
          $display("FAIL run_cadence: tick %0d pose=%0d, required %0d", i, harry_state, (i == 5) ? 3 : 2);
        end
      end
      if (i % 3 == 0) begin
        tick_cycle(1'b0);
        n_checks++;
        if (harry_state !== exp_pose) begin
          n_fail++;
          $display("FAIL run_hold_no_tick: pose=%0d, required %0d", harry_state, exp_pose);
        end
      end
    end
    #3;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if (harry_state !== 4'd0 || jumping !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_mid_run: pose=%0d jumping=%0b, required 0/0", harry_state, jumping);
    end
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_jump();
    int exit_j;
    restart();
    on_ground = 1; jump_req = 1;
    tick_cycle(1'b1);
    jump_req = 0; on_ground = 0;
    for (int i = 0; i < 40; i++) begin
      tick_cycle(1'b1);
      n_checks++;
      if (harry_state !== 4'd1 || jumping !== 1'b1 || model_pose() !== 4'd1) begin
        n_fail++;
        $display("FAIL jump_airborne: tick %0d pose=%0d jumping=%0b, required 1/1", i, harry_state, jumping);
      end
    end
    on_ground = 1; move_left = 1;
    tick_cycle(1'b1);
    n_checks++;
    if (harry_state !== 4'd2 || jumping !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_land_run: pose=%0d jumping=%0b, required 2/0", harry_state, jumping);
    end
    move_left = 0; jump_req = 1;
    tick_cycle(1'b1);
    exit_j = -1;
    for (int j = 1; j <= 40 && exit_j < 0; j++) begin
      tick_cycle(1'b1);
      n_checks++;
      if (harry_state !== model_pose() || jumping !== (m_st == M_JUMP)) begin
        n_fail++;
        $display("FAIL jump_min_model: tick %0d pose=%0d, required %0d", j, harry_state, model_pose());
      end
      if (harry_state !== 4'd1) exit_j = j;
    end
    n_checks++;
    if (exit_j !== JUMP_FRAMES || harry_state !== 4'd0) begin
      n_fail++;
      $display("FAIL jump_min_length: exit tick %0d pose=%0d, required %0d/0", exit_j, harry_state, JUMP_FRAMES);
    end
    tick_cycle(1'b1);
    n_checks++;
    if (harry_state !== 4'd1 || jumping !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_retrigger: pose=%0d jumping=%0b, required 1/1", harry_state, jumping);
    end
  endtask

  task automatic test_vine_ladder();
    restart();
    on_ground = 1; move_right = 1;
    repeat (3) tick_cycle(1'b1);
    on_vine = 1; jump_req = 1;
    tick_cycle(1'b1);
    n_checks++;
    if (harry_state !== 4'd7 || jumping !== 1'b0) begin
      n_fail++;
      $display("FAIL vine_override: pose=%0d jumping=%0b, required 7/0", harry_state, jumping);
    end
    jump_req = 0;
    tick_cycle(1'b1);
    on_vine = 0; on_ladder = 1;
    tick_cycle(1'b1);
    n_checks++;
    if (harry_state !== 4'd8) begin
      n_fail++;
      $display("FAIL vine_to_ladder: pose=%0d, required 8", harry_state);
    end
  endtask

  task automatic test_climb();
    logic [3:0] frozen;
    restart();
    on_ladder = 1; climb_up = 1;
    tick_cycle(1'b1);
    for (int i = 1; i <= 17; i++) begin
      tick_cycle(1'b1);
      n_checks++;
      if (harry_state !== model_pose()) begin
        n_fail++;
        $display("FAIL climb_seq: tick %0d pose=%0d, required %0d", i, harry_state, model_pose());
      end
      if (i == 7 || i == 8 || i == 16) begin
        n_checks++;
        if (harry_state !== ((i == 8) ? 4'd9 : 4'd8)) begin
          n_fail++;
          $display("FAIL climb_cadence: tick %0d pose=%0d, required %0d", i, harry_state, (i == 8) ? 9 : 8);
        end
      end
    end
    frozen = harry_state;
    climb_up = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin climb_up = 1; climb_down = 1; end
      tick_cycle(1'b1);
      n_checks++;
      if (harry_state !== frozen || harry_state !== model_pose()) begin
        n_fail++;
        $display("FAIL climb_frozen: tick %0d pose=%0d, required %0d", i, harry_state, frozen);
      end
    end
  endtask

`ifdef HARRY_FACING_EN
  task automatic test_facing();
    restart();
    on_ground = 1; move_left = 1;
    tick_cycle(1'b1);
    n_checks++;
    if (facing_left !== 1'b1) begin
      n_fail++;
      $display("FAIL facing_set: facing_left=%0b, required 1", facing_left);
    end
    move_right = 1;
    tick_cycle(1'b1);
    n_checks++;
    if (facing_left !== 1'b1 || harry_state !== 4'd0) begin
      n_fail++;
      $display("FAIL facing_both_keys: facing_left=%0b pose=%0d, required 1/0", facing_left, harry_state);
    end
    move_left = 0;
    tick_cycle(1'b1);
    n_checks++;
    if (facing_left !== 1'b0) begin
      n_fail++;
      $display("FAIL facing_clear: facing_left=%0b, required 0", facing_left);
    end
  endtask
`endif

  task automatic test_random();
    restart();
    on_ground = 1;
    for (int i = 0; i < 600; i++) begin
      move_left  = ($urandom_range(0, 2) == 0);
      move_right = ($urandom_range(0, 2) == 0);
      jump_req   = ($urandom_range(0, 5) == 0);
      climb_up   = ($urandom_range(0, 1) == 0);
      climb_down = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0)  on_ground = ~on_ground;
      if ($urandom_range(0, 19) == 0) on_ladder = ~on_ladder;
      if ($urandom_range(0, 29) == 0) on_vine   = ~on_vine;
      tick_cycle($urandom_range(0, 2) != 0);
      n_checks++;
      if (harry_state !== model_pose() || jumping !== (m_st == M_JUMP)) begin
        n_fail++;
        $display("FAIL random: step %0d pose=%0d jumping=%0b, required %0d/%0b",
                 i, harry_state, jumping, model_pose(), (m_st == M_JUMP));
      end
`ifdef HARRY_FACING_EN
      n_checks++;
      if (facing_left !== m_face) begin
        n_fail++;
        $display("FAIL random_facing: step %0d facing_left=%0b, required %0b", i, facing_left, m_face);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_jump();
    test_vine_ladder();
    test_climb();
`ifdef HARRY_FACING_EN
    test_facing();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
